// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared read-owner tag and default starvation threshold for ls_arbiter
package ls_pkg;

  // Who is owed the read data returning from memory next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LS   = 2'd1,
    OWN_DMA  = 2'd2
  } own_e;

  localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/ls_arbiter.sv
// rtl/ls_arbiter.sv - two-requester local-storage arbiter (LS over DMA); optional DMA anti-starvation via LS_ARB_STARVE_EN
module ls_arbiter
  import ls_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [WIDTH-1:0] ls_adr,
  input  logic [WIDTH-1:0] ls_wdata,
  output logic             ls_gnt,
  output logic             ls_rvalid,
  output logic [WIDTH-1:0] ls_rdata,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [WIDTH-1:0] dma_adr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic             dma_gnt,
  output logic             dma_rvalid,
  output logic [WIDTH-1:0] dma_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  own_e             own_q;
  logic [WIDTH-1:0] ls_hold_q;
  logic [WIDTH-1:0] dma_hold_q;
  logic             dma_pri;

`ifdef LS_ARB_STARVE_EN
  logic [7:0] starve_cnt;

  // Count consecutive cycles DMA waits; any grant or a dropped request restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= 8'd0;
    else if (!dma_req || dma_gnt)
      starve_cnt <= 8'd0;
    else if (starve_cnt != 8'hFF)
      starve_cnt <= starve_cnt + 8'd1;
  end

  assign dma_pri = (starve_cnt >= LIMIT);
`else
  logic unused_limit;
  assign unused_limit = ^LIMIT;
  assign dma_pri      = 1'b0;
`endif

  // Single grant per cycle; gated by rst_n so nothing is issued while reset is held
  always_comb begin
    ls_gnt  = 1'b0;
    dma_gnt = 1'b0;
    if (rst_n) begin
      if (dma_req && (dma_pri || !ls_req))
        dma_gnt = 1'b1;
      else if (ls_req)
        ls_gnt = 1'b1;
    end
  end

  // Steer the granted requester onto the memory port; idle port drives zeros
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_read  = !ls_we;
      mem_write = ls_we;
      mem_adr   = ls_adr;
      mem_wdata = ls_wdata;
    end else if (dma_gnt) begin
      mem_read  = !dma_we;
      mem_write = dma_we;
      mem_adr   = dma_adr;
      mem_wdata = dma_wdata;
    end
  end

  // Tag the owner of this cycle's read so the returning data is routed next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      own_q <= OWN_NONE;
    else if (ls_gnt && !ls_we)
      own_q <= OWN_LS;
    else if (dma_gnt && !dma_we)
      own_q <= OWN_DMA;
    else
      own_q <= OWN_NONE;
  end

  // Remember the last delivered data so rdata holds between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_hold_q  <= '0;
      dma_hold_q <= '0;
    end else begin
      if (own_q == OWN_LS)
        ls_hold_q <= mem_rdata;
      if (own_q == OWN_DMA)
        dma_hold_q <= mem_rdata;
    end
  end

  assign ls_rvalid  = (own_q == OWN_LS);
  assign dma_rvalid = (own_q == OWN_DMA);
  assign ls_rdata   = ls_rvalid  ? mem_rdata : ls_hold_q;
  assign dma_rdata  = dma_rvalid ? mem_rdata : dma_hold_q;

endmodule

// File: tb/tb_ls_arbiter.sv
// tb/tb_ls_arbiter.sv - directed self-checking bench for ls_arbiter with a registered RAM model
module tb_ls_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_req, ls_we, dma_req, dma_we;
  logic [31:0] ls_adr, ls_wdata, dma_adr, dma_wdata;
  logic        ls_gnt, ls_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] ls_rdata, dma_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_adr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ram [64];
  bit          loaded;

  ls_arbiter #(.WIDTH(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ls_req(ls_req), .ls_we(ls_we), .ls_adr(ls_adr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) ram[i] <= pat(i);
      loaded <= 1'b1;
    end else begin
      if (mem_write) ram[mem_adr[7:2]] <= mem_wdata;
      if (mem_read) mem_rdata <= ram[mem_adr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_adr = 32'h10; ls_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_adr = 32'h0; dma_wdata = 32'h0;
    settle();
    check("rst ls_gnt", ls_gnt, 0);
    check("rst mem_read", mem_read, 0);
    check("rst mem_adr", mem_adr, 0);
    check("rst ls_rvalid", ls_rvalid, 0);
    check("rst ls_rdata", ls_rdata, 0);
    check("rst dma_rdata", dma_rdata, 0);
    @(posedge clk);
    next_cycle();

    // first cycle out of reset: LS read of 0x10 is granted immediately
    rst_n = 1'b1;
    settle();
    check("n ls_gnt", ls_gnt, 1);
    check("n mem_read", mem_read, 1);
    check("n mem_adr", mem_adr, 32'h10);
    check("n dma_gnt", dma_gnt, 0);
    next_cycle();
    ls_req = 1'b0;
    settle();
    check("n1 ls_rvalid", ls_rvalid, 1);
    check("n1 ls_rdata", ls_rdata, pat(4));
    check("n1 dma_rvalid", dma_rvalid, 0);
    check("n1 mem_read", mem_read, 0);
    check("n1 mem_adr", mem_adr, 0);
    next_cycle();
    settle();
    check("n2 ls_rvalid", ls_rvalid, 0);
    check("n2 ls_rdata hold", ls_rdata, pat(4));

    // both request for 3 cycles: LS wins each, DMA gets the 4th
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      ls_req = 1'b1; ls_adr = 32'h04; dma_req = 1'b1; dma_adr = 32'h08;
      settle();
      check($sformatf("both%0d ls_gnt", c), ls_gnt, 1);
      check($sformatf("both%0d dma_gnt", c), dma_gnt, 0);
      check($sformatf("both%0d mem_adr", c), mem_adr, 32'h04);
    end
    next_cycle();
    ls_req = 1'b0;
    settle();
    check("c4 dma_gnt", dma_gnt, 1);
    check("c4 mem_adr", mem_adr, 32'h08);
    check("c4 ls_rvalid", ls_rvalid, 1);
    check("c4 ls_rdata", ls_rdata, pat(1));
    next_cycle();
    dma_req = 1'b0;
    settle();
    check("c5 dma_rvalid", dma_rvalid, 1);
    check("c5 dma_rdata", dma_rdata, pat(2));
    check("c5 ls_rvalid", ls_rvalid, 0);

    // LS write then DMA read of the same word
    next_cycle();
    ls_req = 1'b1; ls_we = 1'b1; ls_adr = 32'h20; ls_wdata = 32'hDEADBEEF;
    settle();
    check("wr mem_write", mem_write, 1);
    check("wr mem_read", mem_read, 0);
    check("wr mem_adr", mem_adr, 32'h20);
    check("wr mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("wr dma_rvalid", dma_rvalid, 0);
    next_cycle();
    ls_req = 1'b0; ls_we = 1'b0; dma_req = 1'b1; dma_adr = 32'h20;
    settle();
    check("rd dma_gnt", dma_gnt, 1);
    check("rd mem_read", mem_read, 1);
    check("rd ls_rvalid", ls_rvalid, 0);
    next_cycle();
    dma_req = 1'b0;
    settle();
    check("rd dma_rvalid", dma_rvalid, 1);
    check("rd dma_rdata", dma_rdata, 32'hDEADBEEF);
    check("rd2 ls_rvalid", ls_rvalid, 0);

    // alternating LS / DMA reads, one per cycle
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      ls_req  = (i < 4) && (i % 2 == 0);
      dma_req = (i < 4) && (i % 2 == 1);
      ls_adr  = 32'(4 * i);
      dma_adr = 32'(4 * i);
      settle();
      if (i < 4) begin
        check($sformatf("alt%0d ls_gnt", i), ls_gnt, (i % 2 == 0) ? 1 : 0);
        check($sformatf("alt%0d dma_gnt", i), dma_gnt, (i % 2 == 1) ? 1 : 0);
        check($sformatf("alt%0d mem_adr", i), mem_adr, 32'(4 * i));
      end
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          check($sformatf("alt%0d ls_rvalid", i), ls_rvalid, 1);
          check($sformatf("alt%0d dma_rvalid", i), dma_rvalid, 0);
          check($sformatf("alt%0d ls_rdata", i), ls_rdata, pat(i - 1));
        end else begin
          check($sformatf("alt%0d ls_rvalid", i), ls_rvalid, 0);
          check($sformatf("alt%0d dma_rvalid", i), dma_rvalid, 1);
          check($sformatf("alt%0d dma_rdata", i), dma_rdata, pat(i - 1));
        end
      end
    end

    // one-cycle reset pulse coincident with an LS read
    next_cycle();
    ls_req = 1'b1; ls_adr = 32'h10; rst_n = 1'b0;
    settle();
    check("rp ls_gnt", ls_gnt, 0);
    check("rp mem_read", mem_read, 0);
    check("rp mem_adr", mem_adr, 0);
    check("rp ls_rdata", ls_rdata, 0);
    check("rp dma_rdata", dma_rdata, 0);
    next_cycle();
    rst_n = 1'b1; ls_req = 1'b0;
    settle();
    check("rp1 ls_rvalid", ls_rvalid, 0);
    check("rp1 dma_rvalid", dma_rvalid, 0);
    check("rp1 ls_rdata", ls_rdata, 0);
    check("rp1 mem_read", mem_read, 0);

`ifdef LS_ARB_STARVE_EN
    // continuous contention: DMA breaks through on cycle 9, then every 9th
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      ls_req = 1'b1; ls_adr = 32'h0; dma_req = 1'b1; dma_adr = 32'h4;
      settle();
      check($sformatf("stv%0d dma_gnt", c), dma_gnt, (c == 9 || c == 18) ? 1 : 0);
      check($sformatf("stv%0d ls_gnt", c), ls_gnt, (c == 9 || c == 18) ? 0 : 1);
    end
`else
    // continuous contention: strict LS priority never yields
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      ls_req = 1'b1; ls_adr = 32'h0; dma_req = 1'b1; dma_adr = 32'h4;
      settle();
      check($sformatf("strict%0d dma_gnt", c), dma_gnt, 0);
      check($sformatf("strict%0d ls_gnt", c), ls_gnt, 1);
    end
`endif
    next_cycle();
    ls_req = 1'b0; dma_req = 1'b0;
    settle();
    check("end ls_gnt", ls_gnt, 0);
    check("end dma_gnt", dma_gnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ls_arbiter.md
LS_ARBITER -- requirements
Module: ls_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets the data and address width of every port.
REQ-002 Parameter STARVE_LIMIT, default 8, sets the DMA starvation threshold in cycles (range 1..255).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 ls_req, ls_we  input  1 each  load/store request; write when ls_we=1.
REQ-006 ls_adr, ls_wdata  input  WIDTH each  byte address and write data.
REQ-007 ls_gnt  output  1  request accepted this cycle.
REQ-008 ls_rvalid  output  1  ls_rdata is valid.
REQ-009 ls_rdata  output  WIDTH  read data.
REQ-010 dma_req, dma_we, dma_adr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same directions, widths and meanings as the ls_* ports, for the DMA requester.
REQ-011 mem_read, mem_write  output  1 each  strobes to the local-storage memory.
REQ-012 mem_adr, mem_wdata  output  WIDTH each  address and data to the memory.
REQ-013 mem_rdata  input  WIDTH  memory read data, registered inside the memory, valid one cycle after mem_read.

Function
REQ-014 At most one requester shall be granted per cycle; a grant is combinational from the requests and the registered state.
REQ-015 The granted requester's we, adr and wdata shall drive mem_write/mem_read, mem_adr and mem_wdata in the grant cycle; with no grant, mem_read=mem_write=0 and mem_adr/mem_wdata hold 0.
REQ-016 adr shall pass through unmodified; word selection and aliasing belong to the memory.
REQ-017 Default priority: LS over DMA.
REQ-018 A 2-bit registered read-owner tag (NONE/LS/DMA) shall record the owner of each granted read.
REQ-019 In the cycle after a granted read, the owner's rvalid shall be 1 and its rdata shall equal mem_rdata; otherwise rvalid=0 and rdata holds its last value.
REQ-020 A granted write shall produce no rvalid.
REQ-021 Back-to-back reads from either requester are sustained at one per cycle, with no bubble.
REQ-022 Read latency is exactly 1 cycle from grant to rvalid, independent of the other requester's activity.

Reset
REQ-023 While rst_n=0, all grants, strobes and rvalids shall be 0, and mem_adr, mem_wdata, ls_rdata and dma_rdata shall be 0.
REQ-024 While rst_n=0, the read-owner tag shall be NONE and the starvation counter 0.
REQ-025 A read granted in the cycle reset asserts shall produce no rvalid after reset releases.
REQ-026 The first grant is possible in the first rising edge cycle with rst_n=1.

Configuration
REQ-027 Macro LS_ARB_STARVE_EN, when defined, compiles in an 8-bit counter of consecutive cycles with dma_req=1 and dma_gnt=0.
REQ-028 When that counter reaches STARVE_LIMIT, the next cycle shall give DMA priority over LS for one grant, and the counter shall clear on any dma_gnt or when dma_req=0.
REQ-029 With LS_ARB_STARVE_EN undefined, priority is strict LS-first and no counter exists.

Structure
REQ-030 A shared package ls_pkg shall hold the read-owner enum (OWN_NONE, OWN_LS, OWN_DMA) and the default STARVE_LIMIT constant.
REQ-031 No sub-module; the starvation counter is inline, guarded by the macro.

Verification
REQ-032 LS read adr=0x10 alone -> mem_read=1 and mem_adr=0x10 in cycle N; ls_rvalid=1 with ls_rdata=RAM[4] in N+1; dma_rvalid=0.
REQ-033 ls_req and dma_req both held 3 cycles, without the macro -> ls_gnt=1 every cycle, dma_gnt=0; DMA is granted in cycle 4 after ls_req drops.
REQ-034 Macro defined, STARVE_LIMIT=8, both requesting continuously -> dma_gnt=1 exactly on cycle 9, then 8 cycles of LS grants, repeating.
REQ-035 LS write 0xDEADBEEF to 0x20 followed by DMA read of 0x20 -> dma_rdata=0xDEADBEEF one cycle after the DMA grant, and no ls_rvalid.
REQ-036 Alternating LS read / DMA read each cycle -> rvalid and rdata route to the correct owner every cycle, with zero bubbles.
REQ-037 rst_n pulsed low for one cycle coincident with a granted LS read -> no ls_rvalid afterwards, all outputs 0, counter 0.
